// File: rtl/expr_eval_if.sv
`default_nettype none
// ============================================================================
//  Module      : expr_eval_if
//  Description : Character-stream bus for the expression evaluator.
//                master drives one ASCII character per valid cycle;
//                slave (the evaluator) returns the recogniser status.
//  Signals     : valid  - ch carries a character this cycle
//                ch     - ASCII character
//                out    - prefix so far is a complete legal expression
//                err    - sticky syntax error
//                value  - expression value (mod 2^W) while out=1, else 0
//                s      - state code: 0 OPND, 1 NUM, 2 CLOSE, 3 ERR
//                depth  - current open-parenthesis count
//  Revision    : 1.0 - initial release
// ============================================================================
interface expr_eval_if #(
   parameter int W     = 16,
   parameter int DEPTH = 4
);
   localparam int DW = $clog2(DEPTH + 1);

   logic          valid;
   logic [7:0]    ch;
   logic          out;
   logic          err;
   logic [W-1:0]  value;
   logic [1:0]    s;
   logic [DW-1:0] depth;

   modport master (
      output valid, ch,
      input  out, err, value, s, depth
   );

   modport slave (
      input  valid, ch,
      output out, err, value, s, depth
   );
endinterface
`default_nettype wire

// File: rtl/expr_eval.sv
`default_nettype none
// ============================================================================
//  Module      : expr_eval
//  Description : Streaming ASCII expression recogniser/evaluator. Accepts
//                multi-digit decimal numbers, '+' and '*' with standard
//                precedence and (optionally) nested parentheses, one
//                character per valid cycle, and reports whether the prefix
//                seen so far is a complete expression together with its
//                value modulo 2^W.
//  Ports       : clk_i  - clock, all state changes on the rising edge
//                clr_ni - synchronous active-low clear
//                bus    - expr_eval_if.slave (valid/ch in; out, err,
//                         value, s, depth out)
//  Parameters  : W      - value/accumulator width (arithmetic mod 2^W)
//                DEPTH  - maximum parenthesis nesting depth (>=1)
//  Macro       : EXPR_PAREN_EN - when defined, builds the parenthesis
//                stack; when undefined '(' and ')' are illegal and depth
//                reads 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module expr_eval #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       clr_ni,
   expr_eval_if.slave bus
);

   if (DEPTH < 1) begin : g_bad_depth
      $error("expr_eval: DEPTH must be at least 1");
   end
   if (W < 4) begin : g_bad_width
      $error("expr_eval: W must be at least 4");
   end

   typedef enum logic [1:0] {
      S_OPND  = 2'd0,
      S_NUM   = 2'd1,
      S_CLOSE = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   localparam logic [7:0] C_LPAR = 8'h28;
   localparam logic [7:0] C_RPAR = 8'h29;
   localparam logic [7:0] C_MUL  = 8'h2A;
   localparam logic [7:0] C_ADD  = 8'h2B;

   state_t       state_q;
   // sum_q holds the finished terms, prod_q the running product of the
   // current term, cur_q the operand being assembled.
   logic [W-1:0] sum_q;
   logic [W-1:0] prod_q;
   logic [W-1:0] cur_q;

   logic         w_is_digit;
   logic [W-1:0] w_digit;
   logic [W-1:0] w_cur_x10;
   logic [W-1:0] w_prod_cur;
   logic [W-1:0] w_total;
   logic         w_depth_zero;
   logic         w_out;

   // '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
   assign w_is_digit = (bus.ch >= 8'h30) && (bus.ch <= 8'h39);
   assign w_digit    = W'(bus.ch[3:0]);
   assign w_cur_x10  = (cur_q * W'(10)) + w_digit;
   assign w_prod_cur = prod_q * cur_q;
   // Value of the innermost open level if the current operand ended now.
   assign w_total    = sum_q + w_prod_cur;

`ifdef EXPR_PAREN_EN
   localparam int DW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  stk_sum_q  [DEPTH];
   logic [W-1:0]  stk_prod_q [DEPTH];
   logic [DW-1:0] depth_q;
   logic [IW-1:0] w_push_idx;
   logic [IW-1:0] w_pop_idx;
   logic          w_stk_full;

   // The stack grows upward: entry depth_q is the next free slot and
   // depth_q-1 is the level a ')' returns to.
   assign w_push_idx   = IW'(depth_q);
   assign w_pop_idx    = IW'(depth_q - DW'(1));
   assign w_stk_full   = (depth_q == DW'(DEPTH));
   assign w_depth_zero = (depth_q == '0);
   assign bus.depth    = depth_q;
`else
   assign w_depth_zero = 1'b1;
   assign bus.depth    = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
         // Clearing depth alone empties the stack; the entries need no reset.
         state_q <= S_OPND;
         sum_q   <= '0;
         prod_q  <= W'(1);
         cur_q   <= '0;
`ifdef EXPR_PAREN_EN
         depth_q <= '0;
`endif
      end else if (bus.valid) begin
         unique case (state_q)
            S_OPND: begin
               if (w_is_digit) begin
                  cur_q   <= w_digit;
                  state_q <= S_NUM;
               end
`ifdef EXPR_PAREN_EN
               else if (bus.ch == C_LPAR) begin
                  if (w_stk_full) begin
                     state_q <= S_ERR;
                  end else begin
                     stk_sum_q[w_push_idx]  <= sum_q;
                     stk_prod_q[w_push_idx] <= prod_q;
                     sum_q   <= '0;
                     prod_q  <= W'(1);
                     cur_q   <= '0;
                     depth_q <= depth_q + DW'(1);
                  end
               end
`endif
               else begin
                  state_q <= S_ERR;
               end
            end

            S_NUM, S_CLOSE: begin
               if (w_is_digit) begin
                  // A digit straight after ')' has no operator joining it.
                  if (state_q == S_NUM) cur_q   <= w_cur_x10;
                  else                  state_q <= S_ERR;
               end else if (bus.ch == C_MUL) begin
                  prod_q  <= w_prod_cur;
                  cur_q   <= '0;
                  state_q <= S_OPND;
               end else if (bus.ch == C_ADD) begin
                  sum_q   <= w_total;
                  prod_q  <= W'(1);
                  cur_q   <= '0;
                  state_q <= S_OPND;
               end
`ifdef EXPR_PAREN_EN
               else if (bus.ch == C_RPAR) begin
                  if (w_depth_zero) begin
                     state_q <= S_ERR;
                  end else begin
                     // The closed group becomes the operand of the outer level.
                     cur_q   <= w_total;
                     sum_q   <= stk_sum_q[w_pop_idx];
                     prod_q  <= stk_prod_q[w_pop_idx];
                     depth_q <= depth_q - DW'(1);
                     state_q <= S_CLOSE;
                  end
               end
`endif
               else begin
                  state_q <= S_ERR;
               end
            end

            default: begin
               // S_ERR is absorbing until clr_ni falls.
            end
         endcase
      end
   end

   assign w_out     = ((state_q == S_NUM) || (state_q == S_CLOSE)) && w_depth_zero;
   assign bus.out   = w_out;
   assign bus.err   = (state_q == S_ERR);
   assign bus.value = w_out ? w_total : '0;
   assign bus.s     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_expr_eval.sv
`default_nettype none
// ============================================================================
//  Module      : tb_expr_eval
//  Description : Randomised and directed bench for expr_eval. The driver
//                keeps the character history of the current expression and
//                pushes the expected outputs for every cycle into a queue; a
//                monitor pops one entry after each rising edge and compares.
//                Expected values come from a grammar scan of the history and
//                an operator-precedence (shunting-yard) evaluation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_expr_eval;
   localparam int W     = 8;
   localparam int DEPTH = 2;
   localparam int DW    = $clog2(DEPTH + 1);
   localparam longint MASK = (longint'(1) << W) - 1;
`ifdef EXPR_PAREN_EN
   localparam bit PAREN = 1'b1;
`else
   localparam bit PAREN = 1'b0;
`endif

   logic clk = 1'b0;
   logic clr_n;
   always #5 clk = ~clk;

   expr_eval_if #(.W(W), .DEPTH(DEPTH)) bus ();

   expr_eval #(.W(W), .DEPTH(DEPTH)) dut (
      .clk_i  (clk),
      .clr_ni (clr_n),
      .bus    (bus)
   );

   typedef struct {
      bit           out;
      bit           err;
      logic [W-1:0] value;
      logic [1:0]   s;
      int           depth;
   } exp_t;

   exp_t   sb[$];
   byte    hist[$];
   longint m_vals[$];
   byte    m_ops[$];
   int     total = 0;
   int     bad   = 0;
   int     cyc   = 0;

   function automatic void reduce_one();
      byte    op = m_ops.pop_back();
      longint b  = m_vals.pop_back();
      longint a  = m_vals.pop_back();
      m_vals.push_back(op == "*" ? ((a * b) & MASK) : ((a + b) & MASK));
   endfunction

   // Expected outputs for the current history of characters.
   function automatic exp_t model();
      exp_t   e;
      int     d     = 0;
      int     kind  = 0;   // 0 operand expected, 1 after digit, 2 after ')'
      bit     bad_  = 1'b0;
      longint num   = 0;
      bit     innum = 1'b0;
      foreach (hist[i]) begin
         byte c   = hist[i];
         bit  dig = (c >= "0") && (c <= "9");
         if (bad_) break;
         if (kind == 0) begin
            if (dig) kind = 1;
            else if (PAREN && c == "(" && d < DEPTH) d++;
            else bad_ = 1'b1;
         end else begin
            if (dig) begin
               if (kind == 2) bad_ = 1'b1;
            end else if (c == "+" || c == "*") kind = 0;
            else if (PAREN && c == ")" && d > 0) begin
               d--;
               kind = 2;
            end else bad_ = 1'b1;
         end
      end
      e.err   = bad_;
      e.s     = bad_ ? 2'd3 : 2'(kind);
      e.depth = d;
      e.out   = !bad_ && kind != 0 && d == 0;
      e.value = '0;
      if (e.out) begin
         m_vals.delete();
         m_ops.delete();
         foreach (hist[i]) begin
            byte c = hist[i];
            if (c >= "0" && c <= "9") begin
               num   = (num * 10 + longint'(c - "0")) & MASK;
               innum = 1'b1;
            end else begin
               if (innum) begin
                  m_vals.push_back(num);
                  num   = 0;
                  innum = 1'b0;
               end
               if (c == "(") m_ops.push_back(c);
               else if (c == ")") begin
                  while (m_ops[$] != "(") reduce_one();
                  void'(m_ops.pop_back());
               end else if (c == "+") begin
                  while (m_ops.size() > 0 && m_ops[$] != "(") reduce_one();
                  m_ops.push_back(c);
               end else begin
                  while (m_ops.size() > 0 && m_ops[$] == "*") reduce_one();
                  m_ops.push_back(c);
               end
            end
         end
         if (innum) m_vals.push_back(num);
         while (m_ops.size() > 0) reduce_one();
         e.value = W'(m_vals[0]);
      end
      return e;
   endfunction

   // One clock of stimulus; the expectation for the state after the next
   // rising edge is queued at the same time.
   task automatic step(input bit v, input byte c, input bit clr);
      @(negedge clk);
      clr_n     = !clr;
      bus.valid = v;
      bus.ch    = c;
      if (clr) hist.delete();
      else if (v) hist.push_back(c);
      sb.push_back(model());
   endtask

   task automatic send(input string str, input int gap);
      for (int i = 0; i < str.len(); i++) begin
         step(1'b1, str[i], 1'b0);
         for (int g = 0; g < gap; g++) step(1'b0, byte'($urandom_range(0, 255)), 1'b0);
      end
   endtask

   task automatic clear();
      step(1'b0, 8'h00, 1'b1);
   endtask

   always @(posedge clk) begin
      #2;
      cyc++;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         total++;
         if (bus.out !== e.out || bus.err !== e.err || bus.value !== e.value ||
             bus.s !== e.s || bus.depth !== DW'(e.depth)) begin
            bad++;
            $display("FAIL cycle %0d outputs: got out=%b err=%b value=%0d s=%0d depth=%0d, want out=%b err=%b value=%0d s=%0d depth=%0d",
                     cyc, bus.out, bus.err, bus.value, bus.s, bus.depth,
                     e.out, e.err, e.value, e.s, e.depth);
         end
      end
   end

   string alph = "0123456789+*()";
   string junk = " -=a";

   initial begin
      clr_n     = 1'b0;
      bus.valid = 1'b0;
      bus.ch    = 8'h00;

      clear();
      clear();
      send("1+3*2", 0);
      clear();
      send("12*(3+4)", 0);
      clear();
      send("1+*2", 0);
      clear();
      send("5", 0);
      clear();
      send("(((", 0);
      clear();
      send(")", 0);
      clear();
      send("200+100", 0);
      clear();
      send("16*16", 0);
      clear();
      send("4*5", 3);
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, "7", 1'b1);
      step(1'b0, 8'h00, 1'b0);
      send("((1+2)*3)+007", 1);
      clear();
      send("(2)(", 0);
      clear();
      send("9 ", 0);
      clear();

      for (int n = 0; n < 800; n++) begin
         int   r = int'($urandom_range(0, 99));
         exp_t cur_e = model();
         if (r < 3 || (cur_e.err && r < 35)) clear();
         else if (r < 10) step(1'b0, byte'($urandom_range(0, 255)), 1'b0);
         else if (r < 14) begin
            if (r == 13) step(1'b1, byte'($urandom_range(128, 255)), 1'b0);
            else step(1'b1, junk[$urandom_range(0, 3)], 1'b0);
         end else if (r < 60) step(1'b1, alph[$urandom_range(0, 9)], 1'b0);
         else step(1'b1, alph[$urandom_range(10, 13)], 1'b0);
      end
      step(1'b0, 8'h00, 1'b0);

      for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
